sc_psr_condcodes: RTL and testbench

- Processor status register and branch-condition evaluator for the micro-datapath. It is the consumer end of the ALU flag interface.
- Latches the ALU's active-low N/Z/V/C flags into the PSR icc field whenever the ALU asserts its set-code output during a flag-update strobe.
- Supports whole-PSR software write/read (wr/rd %psr).
- Evaluates the SPARC-style 4-bit Bicc condition field against the stored icc and returns a registered branch-taken decision to the control unit.

---
 rtl/sc_psr_condcodes_pkg.sv | 30 +++
 rtl/sc_psr_condcodes_cond_eval.sv | 41 ++++
 rtl/sc_psr_condcodes.sv | 79 +++++++
 tb/tb_sc_psr_condcodes.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_psr_condcodes_pkg.sv
// rtl/sc_psr_condcodes_pkg.sv - shared constants for the PSR condition-code block
package sc_psr_condcodes_pkg;

    // Bicc condition selects; the upper eight are the complements of the lower eight
    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BLE  = 4'b0010;
    localparam logic [3:0] COND_BL   = 4'b0011;
    localparam logic [3:0] COND_BLEU = 4'b0100;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BNE  = 4'b1001;
    localparam logic [3:0] COND_BG   = 4'b1010;
    localparam logic [3:0] COND_BGE  = 4'b1011;
    localparam logic [3:0] COND_BGU  = 4'b1100;
    localparam logic [3:0] COND_BCC  = 4'b1101;
    localparam logic [3:0] COND_BPOS = 4'b1110;
    localparam logic [3:0] COND_BVC  = 4'b1111;

    localparam int ICC_C_OFS = 0;
    localparam int ICC_V_OFS = 1;
    localparam int ICC_Z_OFS = 2;
    localparam int ICC_N_OFS = 3;
    localparam int ICC_WIDTH = 4;

    localparam logic [31:0] PSR_RESET_VALUE = 32'h0000_0000;

endpackage

// File: rtl/sc_psr_condcodes_cond_eval.sv
// rtl/sc_psr_condcodes_cond_eval.sv - combinational Bicc condition evaluator
module sc_cond_eval
    import sc_psr_condcodes_pkg::*;
#(
    parameter int DATAWIDTH_COND = 4
) (
    input  logic [ICC_WIDTH-1:0]      icc,
    input  logic [DATAWIDTH_COND-1:0] cond,
    output logic                      taken
);

    logic flagN;
    logic flagZ;
    logic flagV;
    logic flagC;
    logic baseTaken;

    assign flagN = icc[ICC_N_OFS];
    assign flagZ = icc[ICC_Z_OFS];
    assign flagV = icc[ICC_V_OFS];
    assign flagC = icc[ICC_C_OFS];

    // Only the lower-half predicate is decoded; cond[3] inverts it
    always_comb begin
        baseTaken = 1'b0;
        case (cond[2:0])
            3'b000:  baseTaken = 1'b0;
            3'b001:  baseTaken = flagZ;
            3'b010:  baseTaken = flagZ | (flagN ^ flagV);
            3'b011:  baseTaken = flagN ^ flagV;
            3'b100:  baseTaken = flagC | flagZ;
            3'b101:  baseTaken = flagC;
            3'b110:  baseTaken = flagN;
            3'b111:  baseTaken = flagV;
            default: baseTaken = 1'b0;
        endcase
    end

    assign taken = cond[3] ^ baseTaken;

endmodule

// File: rtl/sc_psr_condcodes.sv
// rtl/sc_psr_condcodes.sv - processor status register with icc capture and branch evaluation
module sc_psr_condcodes
    import sc_psr_condcodes_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int DATAWIDTH_COND = 4,
    parameter int ICC_LSB        = 20
) (
    input  logic                      SC_PSR_CLOCK_50,
    input  logic                      SC_PSR_RESET_InHigh,
    input  logic                      SC_PSR_negative_InLow,
    input  logic                      SC_PSR_zero_InLow,
    input  logic                      SC_PSR_overflow_InLow,
    input  logic                      SC_PSR_carry_InLow,
    input  logic                      SC_PSR_SetCode_In,
    input  logic                      SC_PSR_update_InLow,
    input  logic                      SC_PSR_write_InLow,
    input  logic [DATAWIDTH_BUS-1:0]  SC_PSR_data_InBus,
    input  logic [DATAWIDTH_COND-1:0] SC_PSR_cond_InBus,
    input  logic                      SC_PSR_eval_In,
    output logic [DATAWIDTH_BUS-1:0]  SC_PSR_data_OutBus,
    output logic [ICC_WIDTH-1:0]      SC_PSR_icc_OutBus,
    output logic                      SC_PSR_taken_Out,
    output logic                      SC_PSR_valid_Out
);

    logic [DATAWIDTH_BUS-1:0] psrReg;
    logic [ICC_WIDTH-1:0]     iccStored;
    logic [ICC_WIDTH-1:0]     iccFromAlu;
    logic                     iccUpdate;
    logic                     condTaken;

    assign iccStored = psrReg[ICC_LSB +: ICC_WIDTH];
    assign iccUpdate = ~SC_PSR_update_InLow & SC_PSR_SetCode_In;

    always_comb begin
        iccFromAlu            = '0;
        iccFromAlu[ICC_N_OFS] = ~SC_PSR_negative_InLow;
        iccFromAlu[ICC_Z_OFS] = ~SC_PSR_zero_InLow;
        iccFromAlu[ICC_V_OFS] = ~SC_PSR_overflow_InLow;
        iccFromAlu[ICC_C_OFS] = ~SC_PSR_carry_InLow;
    end

    // Software write outranks a flag update landing on the same edge
    always_ff @(posedge SC_PSR_CLOCK_50 or posedge SC_PSR_RESET_InHigh) begin
        if (SC_PSR_RESET_InHigh) begin
            psrReg <= DATAWIDTH_BUS'(PSR_RESET_VALUE);
        end else if (!SC_PSR_write_InLow) begin
            psrReg <= SC_PSR_data_InBus;
        end else if (iccUpdate) begin
            psrReg[ICC_LSB +: ICC_WIDTH] <= iccFromAlu;
        end
    end

    sc_cond_eval #(
        .DATAWIDTH_COND(DATAWIDTH_COND)
    ) u_cond_eval (
        .icc   (iccStored),
        .cond  (SC_PSR_cond_InBus),
        .taken (condTaken)
    );

    // Evaluation sees the pre-edge PSR; taken holds between requests
    always_ff @(posedge SC_PSR_CLOCK_50 or posedge SC_PSR_RESET_InHigh) begin
        if (SC_PSR_RESET_InHigh) begin
            SC_PSR_taken_Out <= 1'b0;
            SC_PSR_valid_Out <= 1'b0;
        end else begin
            SC_PSR_valid_Out <= SC_PSR_eval_In;
            if (SC_PSR_eval_In) begin
                SC_PSR_taken_Out <= condTaken;
            end
        end
    end

    assign SC_PSR_data_OutBus = psrReg;
    assign SC_PSR_icc_OutBus  = iccStored;

endmodule

// File: tb/tb_sc_psr_condcodes.sv
// tb/tb_sc_psr_condcodes.sv - self-checking bench for sc_psr_condcodes
module tb_sc_psr_condcodes;

    logic        clk;
    logic        rst;
    logic        nIn, zIn, vIn, cIn;
    logic        setCode;
    logic        updateN;
    logic        writeN;
    logic [31:0] dataIn;
    logic [3:0]  cond;
    logic        evalIn;
    logic [31:0] dataOut;
    logic [3:0]  iccOut;
    logic        takenOut;
    logic        validOut;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] mPsr;
    logic        mTaken;
    logic        mValid;

    sc_psr_condcodes dut (
        .SC_PSR_CLOCK_50       (clk),
        .SC_PSR_RESET_InHigh   (rst),
        .SC_PSR_negative_InLow (nIn),
        .SC_PSR_zero_InLow     (zIn),
        .SC_PSR_overflow_InLow (vIn),
        .SC_PSR_carry_InLow    (cIn),
        .SC_PSR_SetCode_In     (setCode),
        .SC_PSR_update_InLow   (updateN),
        .SC_PSR_write_InLow    (writeN),
        .SC_PSR_data_InBus     (dataIn),
        .SC_PSR_cond_InBus     (cond),
        .SC_PSR_eval_In        (evalIn),
        .SC_PSR_data_OutBus    (dataOut),
        .SC_PSR_icc_OutBus     (iccOut),
        .SC_PSR_taken_Out      (takenOut),
        .SC_PSR_valid_Out      (validOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Branch truth written out per mnemonic from the flag meanings
    function automatic logic branchRule(input logic [3:0] icc, input logic [3:0] c);
        logic n, z, v, cy;
        n = icc[3]; z = icc[2]; v = icc[1]; cy = icc[0];
        case (c)
            4'd0:  return 1'b0;
            4'd1:  return z;
            4'd2:  return z || (n != v);
            4'd3:  return n != v;
            4'd4:  return cy || z;
            4'd5:  return cy;
            4'd6:  return n;
            4'd7:  return v;
            4'd8:  return 1'b1;
            4'd9:  return !z;
            4'd10: return !(z || (n != v));
            4'd11: return n == v;
            4'd12: return !(cy || z);
            4'd13: return !cy;
            4'd14: return !n;
            default: return !v;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPsr   = 32'h0;
            mTaken = 1'b0;
            mValid = 1'b0;
        end else begin
            if (evalIn) mTaken = branchRule(mPsr[23:20], cond);
            mValid = evalIn;
            if (!writeN) mPsr = dataIn;
            else if (!updateN && setCode) mPsr[23:20] = {!nIn, !zIn, !vIn, !cIn};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_psr", dataOut, mPsr);
            chk("model_icc", {28'h0, iccOut}, {28'h0, mPsr[23:20]});
            chk("model_valid", {31'h0, validOut}, {31'h0, mValid});
            chk("model_taken", {31'h0, takenOut}, {31'h0, mTaken});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        nIn = 1'b1; zIn = 1'b1; vIn = 1'b1; cIn = 1'b1;
        setCode = 1'b0; updateN = 1'b1; writeN = 1'b1;
        dataIn = 32'h0; cond = 4'h0; evalIn = 1'b0;
    endtask

    logic [15:0] tablePattern;

    initial begin
        tablePattern = 16'b1000_0011_0111_1100;
        rst = 1'b1;
        idleInputs();
        #1;
        chk("reset_psr", dataOut, 32'h0);
        chk("reset_valid", {31'h0, validOut}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // flag capture
        {nIn, zIn, vIn, cIn} = 4'b1011; setCode = 1'b1; updateN = 1'b0;
        step();
        chk("capture_icc", {28'h0, iccOut}, 32'h4);
        chk("capture_psr", dataOut, 32'h0040_0000);
        {nIn, zIn, vIn, cIn} = 4'b0000; setCode = 1'b0; updateN = 1'b0;
        step();
        chk("nosetcode_icc", {28'h0, iccOut}, 32'h4);

        // write priority
        writeN = 1'b0; dataIn = 32'h00F0_0000;
        {nIn, zIn, vIn, cIn} = 4'b1110; setCode = 1'b1; updateN = 1'b0;
        step();
        chk("write_wins", dataOut, 32'h00F0_0000);

        // load icc=1001
        writeN = 1'b1; {nIn, zIn, vIn, cIn} = 4'b0110;
        step();
        chk("icc_1001", dataOut, 32'h0090_0000);
        idleInputs();

        // branch table sweep
        for (int i = 0; i < 16; i++) begin
            evalIn = 1'b1; cond = 4'(i);
            step();
            chk($sformatf("table_valid_%0d", i), {31'h0, validOut}, 32'h1);
            chk($sformatf("table_taken_%0d", i), {31'h0, takenOut}, {31'h0, tablePattern[i]});
        end
        evalIn = 1'b0;
        step();
        chk("table_end_valid", {31'h0, validOut}, 32'h0);

        // no bypass of same-edge update
        {nIn, zIn, vIn, cIn} = 4'b1011; setCode = 1'b1; updateN = 1'b0;
        evalIn = 1'b1; cond = 4'b0001;
        step();
        chk("nobypass_taken", {31'h0, takenOut}, 32'h0);
        chk("nobypass_icc", {28'h0, iccOut}, 32'h4);
        setCode = 1'b0; updateN = 1'b1;
        step();
        chk("rerun_taken", {31'h0, takenOut}, 32'h1);
        evalIn = 1'b0;

        // idle hold
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_valid", {31'h0, validOut}, 32'h0);
            chk("idle_taken", {31'h0, takenOut}, 32'h1);
        end

        // reset mid-cycle with an evaluation in flight
        writeN = 1'b0; dataIn = 32'h1234_5678;
        step();
        writeN = 1'b1;
        evalIn = 1'b1; cond = 4'b1001;
        step();
        chk("preflight_valid", {31'h0, validOut}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midreset_psr", dataOut, 32'h0);
        chk("midreset_taken", {31'h0, takenOut}, 32'h0);
        chk("midreset_valid", {31'h0, validOut}, 32'h0);
        evalIn = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postreset_valid", {31'h0, validOut}, 32'h0);
        end
        chk("postreset_psr", dataOut, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
